// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BHT of 2-bit saturating counters plus a tagged BTB.
// Optional gshare BHT indexing is enabled by defining BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor #(
   parameter int unsigned IDX_BITS = 6,
   parameter int unsigned TAG_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         pred_pc,
   output logic                pred_taken,
   output logic [31:0]         pred_target,
   output logic                pred_hit,
`ifdef BRANCH_PREDICTOR_GSHARE_EN
   output logic [IDX_BITS-1:0] pred_hist,
   input  logic [IDX_BITS-1:0] upd_hist,
`endif
   input  logic                upd_valid,
   input  logic [31:0]         upd_pc,
   input  logic                upd_taken,
   input  logic [31:0]         upd_target,
   input  logic                upd_pred_taken,
   output logic                upd_mispredict,
   output logic [31:0]         perf_branches,
   output logic [31:0]         perf_mispredicts
);

   localparam int unsigned ENTRIES = 2 ** IDX_BITS;
   localparam int unsigned TAG_LSB = IDX_BITS + 2;
   localparam int unsigned TAG_MSB = IDX_BITS + TAG_BITS + 1;

   logic [1:0]          r_ctr    [ENTRIES];
   logic                r_valid  [ENTRIES];
   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [31:0]         r_target [ENTRIES];

   logic                r_mispredict;
   logic [31:0]         r_perf_br;
   logic [31:0]         r_perf_mp;

   logic [IDX_BITS-1:0] w_pidx;
   logic [TAG_BITS-1:0] w_ptag;
   logic [IDX_BITS-1:0] w_uidx;
   logic [TAG_BITS-1:0] w_utag;
   logic [IDX_BITS-1:0] w_bht_pidx;
   logic [IDX_BITS-1:0] w_bht_uidx;
   logic                w_hit;
   logic                w_mp;
   logic [1:0]          w_ctr_nxt;
   logic                w_unused;

   // Saturating 2-bit counter: SNT <-> WNT <-> WT <-> ST.
   function automatic logic [1:0] f_sat(input logic [1:0] c, input logic t);
      logic [1:0] n;
      n = c;
      if (t) begin
         if (c != 2'b11) n = c + 2'b01;
      end else begin
         if (c != 2'b00) n = c - 2'b01;
      end
      return n;
   endfunction

   assign w_pidx = pred_pc[IDX_BITS+1:2];
   assign w_ptag = pred_pc[TAG_MSB:TAG_LSB];
   assign w_uidx = upd_pc[IDX_BITS+1:2];
   assign w_utag = upd_pc[TAG_MSB:TAG_LSB];

   assign w_unused = ^{pred_pc[31:TAG_MSB+1], pred_pc[1:0], upd_pc[31:TAG_MSB+1], upd_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [IDX_BITS-1:0] r_ghr;

   assign w_bht_pidx = w_pidx ^ r_ghr;
   assign w_bht_uidx = w_uidx ^ upd_hist;
   assign pred_hist  = r_ghr;

   // History is committed only from resolved branches, so no repair is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ghr <= '0;
      end else if (upd_valid) begin
         r_ghr <= {r_ghr[IDX_BITS-2:0], upd_taken};
      end
   end
`else
   assign w_bht_pidx = w_pidx;
   assign w_bht_uidx = w_uidx;
`endif

   // Lookup: reads pre-update state, so a same-cycle write is visible next cycle.
   always_comb begin
      w_hit       = r_valid[w_pidx] && (r_tag[w_pidx] == w_ptag);
      pred_hit    = w_hit;
      pred_taken  = w_hit && r_ctr[w_bht_pidx][1];
      pred_target = w_hit ? r_target[w_pidx] : 32'd0;
   end

   assign w_ctr_nxt = f_sat(r_ctr[w_bht_uidx], upd_taken);
   assign w_mp      = upd_valid && (upd_taken ^ upd_pred_taken);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_ctr[i] <= 2'b01;
         end
      end else if (upd_valid) begin
         r_ctr[w_bht_uidx] <= w_ctr_nxt;
      end
   end

   // Not-taken outcomes never allocate or modify BTB entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= 32'd0;
         end
      end else if (upd_valid && upd_taken) begin
         r_valid[w_uidx]  <= 1'b1;
         r_tag[w_uidx]    <= w_utag;
         r_target[w_uidx] <= upd_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mispredict <= 1'b0;
         r_perf_br    <= 32'd0;
         r_perf_mp    <= 32'd0;
      end else begin
         r_mispredict <= w_mp;
         if (upd_valid && (r_perf_br != 32'hFFFF_FFFF)) begin
            r_perf_br <= r_perf_br + 32'd1;
         end
         if (w_mp && (r_perf_mp != 32'hFFFF_FFFF)) begin
            r_perf_mp <= r_perf_mp + 32'd1;
         end
      end
   end

   assign upd_mispredict   = r_mispredict;
   assign perf_branches    = r_perf_br;
   assign perf_mispredicts = r_perf_mp;

endmodule
